// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of an in-order pipeline.
//
// Purpose
//   Keeps the program counter, issues one instruction-memory request per
//   cycle while fetching, and hands each returned instruction (with PC+4) to
//   the IF/ID register. A one-entry hold buffer absorbs a returned
//   instruction when IF/ID is stalled. While a branch sits in ID, fetch
//   stops until EX resolves the branch and supplies the redirect.
//
//   States: FETCH   - request outstanding at PC, accept returned data
//           HOLD    - returned instruction parked in the buffer, IF/ID stalled
//           BR_WAIT - waiting for branch resolution, bubbles delivered
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   ST_if_id_en         IF/ID enable from stall unit (low = hold outputs)
//   ST_br_stall         branch decoded in ID; stop fetching
//   EX_br_resolved      branch outcome valid this cycle
//   EX_take_branch      resolved branch is taken
//   EX_target_pc[31:0]  taken-branch target
//   if_imem_req         instruction-memory request (FETCH only)
//   if_imem_addr[31:0]  request address (current PC)
//   imem_if_valid       imem_if_data valid this cycle
//   imem_if_data[31:0]  returned instruction
//   if_IR_out[31:0]     instruction to IF/ID, `NOOP on a bubble
//   if_NPC_out[31:0]    PC+4 of the delivered instruction
//   if_valid_inst_out   delivered instruction is valid
//   if_fetch_cnt[31:0]  delivered-instruction counter
//   if_stall_cnt[31:0]  HOLD/BR_WAIT cycle counter
//
// Configuration
//   IF_PERF_CNT_EN      when defined, the two performance counters are
//                       implemented (both wrap at 2^32); otherwise the
//                       counter ports are tied to zero and no flops exist.
// -----------------------------------------------------------------------------

`ifndef NOOP
`define NOOP 32'h0000_0013
`endif

module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ST_if_id_en,
    input  logic        ST_br_stall,
    input  logic        EX_br_resolved,
    input  logic        EX_take_branch,
    input  logic [31:0] EX_target_pc,
    output logic        if_imem_req,
    output logic [31:0] if_imem_addr,
    input  logic        imem_if_valid,
    input  logic [31:0] imem_if_data,
    output logic [31:0] if_IR_out,
    output logic [31:0] if_NPC_out,
    output logic        if_valid_inst_out,
    output logic [31:0] if_fetch_cnt,
    output logic [31:0] if_stall_cnt
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_BR_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [31:0] r_ir;
    logic [31:0] r_npc;
    logic        r_valid;

    logic [31:0] w_pc_plus4;
    logic        w_fetch_hit;
    logic        w_deliver;
    logic [31:0] w_deliver_data;
    logic        w_bubble;

    // Natural 32-bit overflow gives the required wrap 0xFFFFFFFC -> 0.
    assign w_pc_plus4 = r_pc + 32'd4;

    // A returned instruction is usable only in FETCH with no branch in ID;
    // a pending branch stall overrides the data.
    assign w_fetch_hit = (r_state == S_FETCH) && !ST_br_stall && imem_if_valid;

    // A real instruction moves into IF/ID either straight from memory or
    // from the hold buffer once the stall unit re-enables IF/ID.
    assign w_deliver = ST_if_id_en &&
                       (w_fetch_hit || (r_state == S_HOLD));

    assign w_deliver_data = (r_state == S_HOLD) ? r_buf : imem_if_data;

    // Enabled cycles that have nothing to hand over become bubbles.
    assign w_bubble = ST_if_id_en && !w_deliver &&
                      ((r_state == S_FETCH) || (r_state == S_BR_WAIT));

    // Request is a decode of the state register, gated so that it stays
    // low for as long as reset is held.
    assign if_imem_req  = (r_state == S_FETCH) && !rst;
    assign if_imem_addr = r_pc;

    assign if_IR_out         = r_ir;
    assign if_NPC_out        = r_npc;
    assign if_valid_inst_out = r_valid;

    // NOTE: all state uses non-blocking assignments so every register in this
    // block samples the pre-edge values of the others, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= 32'd0;
            // NOTE: the buffer is a single register, not a memory array, so it
            // is cleared with the rest; any parked instruction is abandoned.
            r_buf   <= 32'd0;
            r_ir    <= `NOOP;
            r_npc   <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            // Delivered outputs: only change on enabled cycles.
            if (w_deliver) begin
                r_ir    <= w_deliver_data;
                r_npc   <= w_pc_plus4;
                r_valid <= 1'b1;
                r_pc    <= w_pc_plus4;
            end else if (w_bubble) begin
                r_ir    <= `NOOP;
                r_valid <= 1'b0;
            end

            case (r_state)
                S_FETCH: begin
                    if (ST_br_stall) begin
                        // Returned data (if any) is dropped; PC stays put.
                        r_state <= S_BR_WAIT;
                    end else if (imem_if_valid && !ST_if_id_en) begin
                        r_buf   <= imem_if_data;
                        r_state <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    // A branch stall here waits: the buffer is delivered
                    // first, and the stall is seen again from FETCH.
                    if (ST_if_id_en) begin
                        r_state <= S_FETCH;
                    end
                end

                S_BR_WAIT: begin
                    // Resolution wins even if the branch stall is still high.
                    if (EX_br_resolved) begin
                        r_state <= S_FETCH;
                        if (EX_take_branch) begin
                            r_pc <= EX_target_pc;
                        end
                    end
                end

                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_deliver) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (r_state != S_FETCH) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign if_fetch_cnt = r_fetch_cnt;
    assign if_stall_cnt = r_stall_cnt;
`else
    assign if_fetch_cnt = 32'd0;
    assign if_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset: clk input 1 (all state updates on rising edge); rst input 1 (synchronous, active-high).
REQ-002 ST_if_id_en  input  1  IF/ID enable from stall unit; low = hold delivered outputs.
REQ-003 ST_br_stall  input  1  branch decoded in ID; fetch SHALL stop until resolution.
REQ-004 EX_br_resolved  input  1  branch outcome valid this cycle.
REQ-005 EX_take_branch  input  1  resolved branch taken.
REQ-006 EX_target_pc  input  32  taken-branch target.
REQ-007 if_imem_req  output  1  instruction-memory request.
REQ-008 if_imem_addr  output  32  request address (current PC).
REQ-009 imem_if_valid  input  1  imem_if_data valid this cycle.
REQ-010 imem_if_data  input  32  returned instruction.
REQ-011 if_IR_out  output  32  instruction to IF/ID; `NOOP when bubble.
REQ-012 if_NPC_out  output  32  PC+4 of delivered instruction.
REQ-013 if_valid_inst_out  output  1  delivered instruction valid.
REQ-014 if_fetch_cnt, if_stall_cnt  output  32 each  perf counters (see Configuration).

Function
REQ-015 States SHALL be FETCH, HOLD, BR_WAIT; 32-bit PC register; 32-bit one-entry hold buffer.
REQ-016 FETCH: if_imem_req=1, if_imem_addr=PC; HOLD and BR_WAIT: if_imem_req=0.
REQ-017 FETCH, imem_if_valid=1, ST_if_id_en=1, ST_br_stall=0: next cycle if_IR_out=imem_if_data, if_NPC_out=PC+4, if_valid_inst_out=1; PC<=PC+4; stay FETCH (one-cycle latency).
REQ-018 FETCH, imem_if_valid=1, ST_if_id_en=0, ST_br_stall=0: data captured into buffer, outputs held, PC unchanged, go HOLD.
REQ-019 HOLD: outputs held while ST_if_id_en=0; on ST_if_id_en=1 deliver buffer (valid=1, NPC=PC+4), PC<=PC+4, go FETCH.
REQ-020 FETCH, imem_if_valid=0, ST_if_id_en=1: deliver bubble (if_IR_out=`NOOP, valid=0); PC unchanged.
REQ-021 ST_br_stall=1 in FETCH SHALL take priority over imem_if_valid: returned data discarded, PC unchanged, bubble delivered if ST_if_id_en=1, go BR_WAIT.
REQ-022 ST_br_stall=1 in HOLD SHALL NOT discard the buffer; BR_WAIT entered only after buffer delivery.
REQ-023 BR_WAIT: bubble delivered each enabled cycle; on EX_br_resolved=1, PC<=EX_target_pc if EX_take_branch else PC unchanged; go FETCH next cycle.
REQ-024 EX_br_resolved=1 coincident with ST_br_stall=1 in BR_WAIT: resolution SHALL win, go FETCH.
REQ-025 EX_br_resolved outside BR_WAIT SHALL be ignored.
REQ-026 PC+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000); no alignment check on EX_target_pc.

Reset
REQ-027 rst=1 SHALL force state FETCH, PC=0, buffer=0, if_IR_out=`NOOP, if_NPC_out=0, if_valid_inst_out=0, counters=0, if_imem_req=0 while rst high.
REQ-028 rst in any state mid-operation SHALL abandon buffered/pending data; first request after rst release uses address 0.

Configuration
REQ-029 Macro IF_PERF_CNT_EN defined: if_fetch_cnt increments per valid instruction delivered, if_stall_cnt per cycle in HOLD or BR_WAIT, both wrap at 2^32.
REQ-030 IF_PERF_CNT_EN undefined: counter ports SHALL remain present and tied to 0; no counter flops.

Verification
REQ-031 Reset then imem_if_valid=1 every cycle, data=0x11,0x22,0x33, ST_if_id_en=1 -> addrs 0,4,8; IR 0x11,0x22,0x33 on successive cycles, NPC 4,8,12.
REQ-032 Data 0xAA returned at PC=0x10 with ST_if_id_en=0 for 3 cycles -> HOLD, req=0, outputs held; enable high -> IR=0xAA, NPC=0x14, next addr 0x14.
REQ-033 ST_br_stall=1 at PC=0x20 with data valid -> data dropped, bubbles; EX_br_resolved=1, EX_take_branch=1, target 0x100 -> next addr 0x100.
REQ-034 Same with EX_take_branch=0 -> next addr 0x20; resolution coincident with ST_br_stall=1 still exits to FETCH.
REQ-035 PC=0xFFFFFFFC fetched -> NPC=0, next addr 0; rst asserted in BR_WAIT -> next addr 0, valid=0.
REQ-036 With IF_PERF_CNT_EN: 5 delivered, 3 stall cycles -> if_fetch_cnt=5, if_stall_cnt=3; without macro both read 0.
